// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared watch types and constants for the countdown timer
// Contents: BCD digit type, timer state enum, mode select codes, digit limits,
//           preset clamp helper.
package countdown_timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } timer_state_t;

  localparam logic [1:0] SEL_STOPWATCH = 2'b01;
  localparam logic [1:0] SEL_TIMER     = 2'b10;

  localparam bcd_t TENS_MAX = 4'd5;
  localparam bcd_t ONES_MAX = 4'd9;

  // Saturate an out-of-range preset digit to the largest legal value.
  function automatic bcd_t clamp_digit(bcd_t d, bcd_t maxv);
    return (d > maxv) ? maxv : d;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - button, preset and display signals of the countdown timer
// master: drives tick1s, sel, start, load, preset digits; reads digit outputs, running, alarm.
// slave:  the timer side of the same signals.
interface countdown_timer_if;
  import countdown_timer_pkg::*;

  logic       tick1s;
  logic [1:0] sel;
  logic       start;
  logic       load;
  bcd_t       preset_tenmin;
  bcd_t       preset_onemin;
  bcd_t       preset_tensec;
  bcd_t       preset_onesec;
  bcd_t       tenminout;
  bcd_t       oneminout;
  bcd_t       tensecout;
  bcd_t       onesecout;
  logic       running;
  logic       alarm;

  modport master (
    output tick1s, sel, start, load,
    output preset_tenmin, preset_onemin, preset_tensec, preset_onesec,
    input  tenminout, oneminout, tensecout, onesecout, running, alarm
  );

  modport slave (
    input  tick1s, sel, start, load,
    input  preset_tenmin, preset_onemin, preset_tensec, preset_onesec,
    output tenminout, oneminout, tensecout, onesecout, running, alarm
  );

endinterface

// File: rtl/countdown_timer_bcd_mmss_dec.sv
// rtl/countdown_timer_bcd_mmss_dec.sv - combinational MM:SS BCD decrement with borrow chain
// Inputs:  tenmin, onemin, tensec, onesec  current BCD time.
// Outputs: dec_tenmin..dec_onesec  time minus one second; is_zero  result equals 00:00.
module bcd_mmss_dec
  import countdown_timer_pkg::*;
(
  input  bcd_t tenmin,
  input  bcd_t onemin,
  input  bcd_t tensec,
  input  bcd_t onesec,
  output bcd_t dec_tenmin,
  output bcd_t dec_onemin,
  output bcd_t dec_tensec,
  output bcd_t dec_onesec,
  output logic is_zero
);

  always_comb begin
    dec_tenmin = tenmin;
    dec_onemin = onemin;
    dec_tensec = tensec;
    dec_onesec = onesec - 4'd1;
    // Each digit at zero wraps to its maximum and borrows from the next one up.
    if (onesec == 4'd0) begin
      dec_onesec = ONES_MAX;
      if (tensec == 4'd0) begin
        dec_tensec = TENS_MAX;
        if (onemin == 4'd0) begin
          dec_onemin = ONES_MAX;
          dec_tenmin = tenmin - 4'd1;
        end else begin
          dec_onemin = onemin - 4'd1;
        end
      end else begin
        dec_tensec = tensec - 4'd1;
      end
    end
    is_zero = (dec_tenmin == 4'd0) && (dec_onemin == 4'd0) &&
              (dec_tensec == 4'd0) && (dec_onesec == 4'd0);
  end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - MM:SS countdown timer with start/pause, load and bounded alarm
// Ports: clk100MHz  system clock; rst  synchronous active-high reset;
//        tif (slave)  tick1s, sel, start, load, preset digits in;
//                     registered digit outputs, running, alarm out.
// Parameter: ALARM_SECS  number of 1 Hz ticks the alarm stays high (1..255).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int ALARM_SECS = 10
) (
  input  logic           clk100MHz,
  input  logic           rst,
  countdown_timer_if.slave tif
);

  localparam logic [7:0] ALARM_INIT = ALARM_SECS[7:0];

  timer_state_t state, state_nxt;
  bcd_t         c_tm, c_om, c_ts, c_os;
  bcd_t         n_tm, n_om, n_ts, n_os;
  bcd_t         d_tm, d_om, d_ts, d_os;
  bcd_t         p_tm, p_om, p_ts, p_os;
  logic         dec_zero;
  logic         cnt_zero;
  logic [7:0]   acnt, acnt_nxt;
  logic         start_q, load_q;
  logic         start_e, load_e;

  // Buttons only count in timer mode; the previous-level registers reset
  // high so a button held through reset is not seen as a fresh press.
  assign start_e = tif.start & ~start_q & (tif.sel == SEL_TIMER);
  assign load_e  = tif.load  & ~load_q  & (tif.sel == SEL_TIMER);

  assign p_tm = clamp_digit(tif.preset_tenmin, TENS_MAX);
  assign p_om = clamp_digit(tif.preset_onemin, ONES_MAX);
  assign p_ts = clamp_digit(tif.preset_tensec, TENS_MAX);
  assign p_os = clamp_digit(tif.preset_onesec, ONES_MAX);

  assign cnt_zero = (c_tm == 4'd0) && (c_om == 4'd0) && (c_ts == 4'd0) && (c_os == 4'd0);

  bcd_mmss_dec u_dec (
    .tenmin     (c_tm),
    .onemin     (c_om),
    .tensec     (c_ts),
    .onesec     (c_os),
    .dec_tenmin (d_tm),
    .dec_onemin (d_om),
    .dec_tensec (d_ts),
    .dec_onesec (d_os),
    .is_zero    (dec_zero)
  );

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      state   <= IDLE;
      c_tm    <= 4'd0;
      c_om    <= 4'd0;
      c_ts    <= 4'd0;
      c_os    <= 4'd0;
      acnt    <= 8'd0;
      start_q <= 1'b1;
      load_q  <= 1'b1;
    end else begin
      state   <= state_nxt;
      c_tm    <= n_tm;
      c_om    <= n_om;
      c_ts    <= n_ts;
      c_os    <= n_os;
      acnt    <= acnt_nxt;
      start_q <= tif.start;
      load_q  <= tif.load;
    end
  end

  always_comb begin
    state_nxt = state;
    n_tm      = c_tm;
    n_om      = c_om;
    n_ts      = c_ts;
    n_os      = c_os;
    acnt_nxt  = acnt;
    unique case (state)
      IDLE: begin
        if (load_e) begin
          {n_tm, n_om, n_ts, n_os} = {p_tm, p_om, p_ts, p_os};
        end else if (start_e && !cnt_zero) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (tif.tick1s) begin
          {n_tm, n_om, n_ts, n_os} = {d_tm, d_om, d_ts, d_os};
          // Reaching 00:00 takes priority over a pause request in the same cycle.
          if (dec_zero) begin
            state_nxt = ALARM;
            acnt_nxt  = ALARM_INIT;
          end else if (start_e) begin
            state_nxt = PAUSE;
          end
        end else if (start_e) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (load_e) begin
          {n_tm, n_om, n_ts, n_os} = {p_tm, p_om, p_ts, p_os};
          state_nxt = IDLE;
        end else if (start_e) begin
          state_nxt = RUN;
        end
      end
      ALARM: begin
        if (load_e) begin
          {n_tm, n_om, n_ts, n_os} = {p_tm, p_om, p_ts, p_os};
          acnt_nxt  = 8'd0;
          state_nxt = IDLE;
        end else if (start_e) begin
          acnt_nxt  = 8'd0;
          state_nxt = IDLE;
        end else if (tif.tick1s) begin
          acnt_nxt = acnt - 8'd1;
          if (acnt == 8'd1) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Display-side copies lag the internal state by one cycle.
  always_ff @(posedge clk100MHz) begin
    tif.tenminout <= c_tm;
    tif.oneminout <= c_om;
    tif.tensecout <= c_ts;
    tif.onesecout <= c_os;
    tif.running   <= (state == RUN);
    tif.alarm     <= (state == ALARM);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer
module tb_countdown_timer;

  localparam int ALARM_N = 10;

  logic clk100MHz = 1'b0;
  logic rst = 1'b1;

  countdown_timer_if tif ();

  countdown_timer #(.ALARM_SECS(ALARM_N)) dut (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .tif       (tif)
  );

  always #5 clk100MHz = ~clk100MHz;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    bit        tick;
    bit        start;
    bit        load;
    bit [1:0]  sel;
    bit [15:0] preset;
    bit [15:0] exp_digits;
    bit        exp_run;
    bit        exp_alarm;
  } vec_t;

  vec_t tbl[$];

  // Reference model: remaining time as plain seconds, mode 0 idle/1 run/2 pause/3 alarm.
  int m_secs, m_mode, m_acnt;
  bit m_sq, m_lq;
  int e_secs;
  bit e_run, e_alarm;

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int preset_secs(bit [15:0] p);
    return min_i(int'(p[15:12]), 5) * 600 + min_i(int'(p[11:8]), 9) * 60 +
           min_i(int'(p[7:4]), 5) * 10 + min_i(int'(p[3:0]), 9);
  endfunction

  function automatic bit [15:0] to_bcd(int s);
    bit [15:0] r;
    r[15:12] = 4'(s / 600);
    r[11:8]  = 4'((s / 60) % 10);
    r[7:4]   = 4'((s % 60) / 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  task automatic model_edge();
    bit se, le;
    int pv;
    e_secs  = m_secs;
    e_run   = (m_mode == 1);
    e_alarm = (m_mode == 3);
    if (rst) begin
      m_secs = 0; m_mode = 0; m_acnt = 0; m_sq = 1; m_lq = 1;
      return;
    end
    se = tif.start && !m_sq && (tif.sel == 2'b10);
    le = tif.load  && !m_lq && (tif.sel == 2'b10);
    m_sq = tif.start;
    m_lq = tif.load;
    pv = preset_secs({tif.preset_tenmin, tif.preset_onemin, tif.preset_tensec, tif.preset_onesec});
    case (m_mode)
      0: begin
        if (le) m_secs = pv;
        else if (se && m_secs != 0) m_mode = 1;
      end
      1: begin
        if (tif.tick1s) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin m_mode = 3; m_acnt = ALARM_N; end
          else if (se) m_mode = 2;
        end else if (se) m_mode = 2;
      end
      2: begin
        if (le) begin m_secs = pv; m_mode = 0; end
        else if (se) m_mode = 1;
      end
      default: begin
        if (le) begin m_secs = pv; m_mode = 0; end
        else if (se) m_mode = 0;
        else if (tif.tick1s) begin
          m_acnt = m_acnt - 1;
          if (m_acnt == 0) m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [17:0] dut_out();
    return {tif.tenminout, tif.oneminout, tif.tensecout, tif.onesecout, tif.running, tif.alarm};
  endfunction

  task automatic drive(bit tick, bit start, bit load, bit [1:0] sel, bit [15:0] preset);
    tif.tick1s = tick;
    tif.start  = start;
    tif.load   = load;
    tif.sel    = sel;
    {tif.preset_tenmin, tif.preset_onemin, tif.preset_tensec, tif.preset_onesec} = preset;
    @(posedge clk100MHz);
    model_edge();
    @(negedge clk100MHz);
  endtask

  // One active cycle, then one quiet cycle so the registered outputs show its result.
  task automatic apply(bit tick, bit start, bit load, bit [1:0] sel, bit [15:0] preset);
    drive(tick, start, load, sel, preset);
    drive(1'b0, start, load, sel, preset);
  endtask

  function automatic void add(bit tick, bit start, bit load, bit [1:0] sel, bit [15:0] preset,
                              bit [15:0] d, bit r, bit a);
    vec_t v;
    v.tick = tick; v.start = start; v.load = load; v.sel = sel; v.preset = preset;
    v.exp_digits = d; v.exp_run = r; v.exp_alarm = a;
    tbl.push_back(v);
  endfunction

  localparam int ALARM_AT = 13;

  initial begin
    bit st, ld;
    bit [1:0] sl;
    bit [15:0] pr;

    // Part 1: count 01:05 down, pause, load 00:02 and run into the alarm.
    add(0,0,1,2'b10,16'h0105, 16'h0105,0,0);
    add(0,1,0,2'b10,16'h0105, 16'h0105,1,0);
    add(1,0,0,2'b10,16'h0105, 16'h0104,1,0);
    add(1,0,0,2'b10,16'h0105, 16'h0103,1,0);
    add(1,0,0,2'b10,16'h0105, 16'h0102,1,0);
    add(1,0,0,2'b10,16'h0105, 16'h0101,1,0);
    add(1,0,0,2'b10,16'h0105, 16'h0100,1,0);
    add(1,0,0,2'b10,16'h0105, 16'h0059,1,0);
    add(0,1,0,2'b10,16'h0105, 16'h0059,0,0);
    add(0,0,1,2'b10,16'h0002, 16'h0002,0,0);
    add(0,1,0,2'b10,16'h0002, 16'h0002,1,0);
    add(1,0,0,2'b10,16'h0002, 16'h0001,1,0);
    add(1,0,0,2'b10,16'h0002, 16'h0000,0,1);
    // Part 2: zero start ignored, clamp, sel gating, pause/resume, simultaneous events.
    add(0,1,0,2'b10,16'h0000, 16'h0000,0,0);
    add(0,0,1,2'b10,16'h7989, 16'h5959,0,0);
    add(0,1,0,2'b10,16'h7989, 16'h5959,1,0);
    add(1,0,0,2'b10,16'h7989, 16'h5958,1,0);
    add(0,1,0,2'b01,16'h7989, 16'h5958,1,0);
    add(0,0,0,2'b10,16'h7989, 16'h5958,1,0);
    add(0,1,0,2'b10,16'h7989, 16'h5958,0,0);
    add(1,0,0,2'b10,16'h7989, 16'h5958,0,0);
    add(1,0,0,2'b10,16'h7989, 16'h5958,0,0);
    add(1,1,0,2'b10,16'h7989, 16'h5958,1,0);
    add(1,0,0,2'b10,16'h7989, 16'h5957,1,0);
    add(0,1,0,2'b10,16'h7989, 16'h5957,0,0);
    add(0,0,1,2'b10,16'h0010, 16'h0010,0,0);
    add(0,1,0,2'b10,16'h0010, 16'h0010,1,0);
    add(0,0,0,2'b10,16'h0010, 16'h0010,1,0);
    add(1,1,0,2'b10,16'h0010, 16'h0009,0,0);
    add(0,0,0,2'b10,16'h0030, 16'h0009,0,0);
    add(0,1,1,2'b10,16'h0030, 16'h0030,0,0);
    add(0,0,0,2'b10,16'h0001, 16'h0030,0,0);
    add(0,1,1,2'b10,16'h0001, 16'h0001,0,0);
    add(0,0,0,2'b10,16'h0001, 16'h0001,0,0);
    add(0,1,0,2'b10,16'h0001, 16'h0001,1,0);
    add(0,0,0,2'b10,16'h0001, 16'h0001,1,0);
    add(1,1,0,2'b10,16'h0001, 16'h0000,0,1);
    add(0,0,0,2'b10,16'h0001, 16'h0000,0,1);
    add(0,1,0,2'b10,16'h0001, 16'h0000,0,0);
    add(0,0,0,2'b10,16'h0001, 16'h0000,0,0);
    add(0,0,1,2'b10,16'h0200, 16'h0200,0,0);
    add(0,1,0,2'b10,16'h0200, 16'h0200,1,0);
    add(1,1,0,2'b10,16'h0200, 16'h0159,1,0);

    // Reset state.
    rst = 1'b1;
    drive(0,0,0,2'b10,16'h0000);
    drive(0,0,0,2'b10,16'h0000);
    drive(0,0,0,2'b10,16'h0000);
    rst = 1'b0;
    drive(0,0,0,2'b10,16'h0000);
    check("reset_digits", 32'(dut_out() >> 2), 32'h0);
    check("reset_running", 32'(tif.running), 32'h0);
    check("reset_alarm", 32'(tif.alarm), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].tick, tbl[i].start, tbl[i].load, tbl[i].sel, tbl[i].preset);
      check($sformatf("vec%0d", i), 32'(dut_out()),
            32'({tbl[i].exp_digits, tbl[i].exp_run, tbl[i].exp_alarm}));
      if (i == ALARM_AT - 1) begin
        // Alarm holds for exactly ALARM_N ticks.
        for (int k = 1; k <= ALARM_N; k++) begin
          apply(1,0,0,2'b10,16'h0002);
          check($sformatf("alarm_tick%0d", k), 32'(dut_out()),
                32'({16'h0000, 1'b0, (k < ALARM_N)}));
        end
      end
    end

    // Reset mid-count with start and load held high through it.
    rst = 1'b1;
    drive(0,1,1,2'b10,16'h0300);
    rst = 1'b0;
    drive(0,1,1,2'b10,16'h0300);
    check("rst_midcount", 32'(dut_out()), 32'h0);
    apply(1,1,1,2'b10,16'h0300);
    apply(1,1,1,2'b10,16'h0300);
    check("held_buttons_no_fire", 32'(dut_out()), 32'h0);

    // Randomized run against the reference model.
    rst = 1'b1;
    drive(0,0,0,2'b10,16'h0000);
    rst = 1'b0;
    st = 0; ld = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0,5) == 0) st = ~st;
      if ($urandom_range(0,9) == 0) ld = ~ld;
      sl = ($urandom_range(0,7) == 0) ? 2'($urandom_range(0,3)) : 2'b10;
      pr = ($urandom_range(0,1) == 1) ? 16'($urandom) : {12'h000, 4'($urandom_range(0,3))};
      rst = ($urandom_range(0,399) == 0);
      drive(($urandom_range(0,2) == 0), st, ld, sl, pr);
      check("random", 32'(dut_out()), 32'({to_bcd(e_secs), e_run, e_alarm}));
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
